// File: rtl/imem_pkg.sv
// Shared definitions for the multi-port instruction memory loader.
// Contents:
//   ld_state_e        load-control FSM state (IDLE / LOADING / ARMED)
//   NOP_WORD_DEFAULT  word returned for addresses that hold no loaded data
//   lane_lo()         low bit index of lane 'lane' in a packed per-port bus
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOADING = 2'd1,
    ARMED   = 2'd2
  } ld_state_e;

  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

  // Packed per-port buses place port i at [i*width +: width].
  function automatic int unsigned lane_lo(input int unsigned lane,
                                          input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/imem_multiport_loader_if.sv
// Bus interface of the multi-port instruction memory loader.
// Groups the instruction-fetch read ports and the program-load channel.
//   rd_addr / rd_data   packed read ports, port i at [i*W +: W]
//   ld_valid / ld_ready load beat handshake
//   ld_addr / ld_data   load beat payload, ld_last ends a program
//   ld_clear            single-cycle discard of the loaded program
//   cpu_hold            high while no complete program is armed
//   ld_count            accepted beats, saturating at 2**ADDR_W
//   err_dup             sticky duplicate-address write flag
// Modports: master = program loader / CPU side, slave = memory.
interface imem_multiport_loader_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32,
  parameter int NUM_RD = 2
);

  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic                     ld_valid;
  logic                     ld_ready;
  logic [ADDR_W-1:0]        ld_addr;
  logic [DATA_W-1:0]        ld_data;
  logic                     ld_last;
  logic                     ld_clear;
  logic                     cpu_hold;
  logic [ADDR_W:0]          ld_count;
  logic                     err_dup;

  modport master (
    output rd_addr, ld_valid, ld_addr, ld_data, ld_last, ld_clear,
    input  rd_data, ld_ready, cpu_hold, ld_count, err_dup
  );

  modport slave (
    input  rd_addr, ld_valid, ld_addr, ld_data, ld_last, ld_clear,
    output rd_data, ld_ready, cpu_hold, ld_count, err_dup
  );

endinterface

// File: rtl/imem_read_port.sv
// One instruction-fetch read port: masks the addressed memory word with its
// valid bit, returning NOP_WORD for words never loaded.
// Ports:
//   CLK, RST, ld_clear  present only when IMEM_RDREG_EN is defined
//   hit                 valid bit of the addressed word
//   word                raw memory word at the addressed location
//   rd_data             masked read data
// Macro IMEM_RDREG_EN: registers rd_data (one-cycle latency); the register
// resets to NOP_WORD and reloads NOP_WORD the cycle after ld_clear.
module imem_read_port
  import imem_pkg::*;
#(
  parameter int              DATA_W   = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
`ifdef IMEM_RDREG_EN
  input  logic              CLK,
  input  logic              RST,
  input  logic              ld_clear,
`endif
  input  logic              hit,
  input  logic [DATA_W-1:0] word,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] rd_data_p0;

  assign rd_data_p0 = hit ? word : NOP_WORD;

`ifdef IMEM_RDREG_EN
  // p0 -> p1: registered read
  logic [DATA_W-1:0] rd_data_p1;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)           rd_data_p1 <= NOP_WORD;
    else if (ld_clear) rd_data_p1 <= NOP_WORD;
    else               rd_data_p1 <= rd_data_p0;
  end

  assign rd_data = rd_data_p1;
`else
  assign rd_data = rd_data_p0;
`endif

endmodule

// File: rtl/imem_multiport_loader.sv
// Parametrised instruction memory with NUM_RD independent read ports and a
// valid/ready program-load channel. A per-word valid bitmap masks contents
// that were not loaded since the last reset/clear; the load FSM
// (IDLE -> LOADING -> ARMED) releases cpu_hold once a beat with ld_last lands.
// Ports:
//   CLK   rising-edge clock
//   RST   asynchronous active-high reset
//   bus   imem_multiport_loader_if.slave (read ports + load channel)
// Macro IMEM_RDREG_EN: registered read ports (see imem_read_port).
module imem_multiport_loader
  import imem_pkg::*;
#(
  parameter int                ADDR_W   = 6,
  parameter int                DATA_W   = 32,
  parameter int                NUM_RD   = 2,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEFAULT)
) (
  input logic CLK,
  input logic RST,
  imem_multiport_loader_if.slave bus
);

  localparam int              DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] COUNT_MAX = (ADDR_W + 1)'(DEPTH);

  ld_state_e         state_q, state_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [ADDR_W:0]   ld_count_q;
  logic              err_dup_q;
  logic              cpu_hold_q;
  logic              ld_ready_c;
  logic              accept;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.ld_clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, LOADING: if (accept) state_d = bus.ld_last ? ARMED : LOADING;
        ARMED:         state_d = ARMED;
        default:       state_d = IDLE;
      endcase
    end
  end

  // A clear pulse blocks any beat presented in the same cycle.
  always_comb begin
    ld_ready_c = (state_q != ARMED) && !bus.ld_clear;
  end

  assign accept = bus.ld_valid && ld_ready_c;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_q    <= '0;
      ld_count_q <= '0;
      err_dup_q  <= 1'b0;
      cpu_hold_q <= 1'b1;
    end else begin
      cpu_hold_q <= (state_d != ARMED);
      if (bus.ld_clear) begin
        valid_q    <= '0;
        ld_count_q <= '0;
        err_dup_q  <= 1'b0;
      end else if (accept) begin
        valid_q[bus.ld_addr] <= 1'b1;
        if (valid_q[bus.ld_addr]) err_dup_q <= 1'b1;
        if (ld_count_q != COUNT_MAX) ld_count_q <= ld_count_q + (ADDR_W + 1)'(1);
      end
    end
  end

  // Storage is never cleared; the valid bitmap hides stale words.
  always_ff @(posedge CLK) begin
    if (accept) mem[bus.ld_addr] <= bus.ld_data;
  end

  assign bus.ld_ready = ld_ready_c;
  assign bus.cpu_hold = cpu_hold_q;
  assign bus.ld_count = ld_count_q;
  assign bus.err_dup  = err_dup_q;

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [ADDR_W-1:0] addr_c;

    assign addr_c = bus.rd_addr[lane_lo(gi, ADDR_W) +: ADDR_W];

    imem_read_port #(
      .DATA_W   (DATA_W),
      .NOP_WORD (NOP_WORD)
    ) u_port (
`ifdef IMEM_RDREG_EN
      .CLK      (CLK),
      .RST      (RST),
      .ld_clear (bus.ld_clear),
`endif
      .hit      (valid_q[addr_c]),
      .word     (mem[addr_c]),
      .rd_data  (bus.rd_data[lane_lo(gi, DATA_W) +: DATA_W])
    );
  end

endmodule

// File: tb/tb_imem_multiport_loader.sv
// Directed bench for imem_multiport_loader: a vector table for the main
// load/read/clear flow, hand sequences for read-during-write, reset mid-load
// and ld_count saturation on a 4-port, 256-word instance.
module tb_imem_multiport_loader;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  imem_multiport_loader_if #(.ADDR_W(6), .DATA_W(32), .NUM_RD(2)) bus ();
  imem_multiport_loader_if #(.ADDR_W(8), .DATA_W(32), .NUM_RD(4)) bbus ();

  imem_multiport_loader #(.ADDR_W(6), .DATA_W(32), .NUM_RD(2)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  imem_multiport_loader #(.ADDR_W(8), .DATA_W(32), .NUM_RD(4)) dut_big (
    .CLK (clk),
    .RST (rst),
    .bus (bbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [5:0]  a;
    logic [31:0] d;
    logic        last;
    logic        clr;
    logic [5:0]  ra0;
    logic [5:0]  ra1;
    logic        e_ready;
    logic [6:0]  e_cnt;
    logic        e_hold;
    logic        e_err;
    logic [31:0] e_rd0;
    logic [31:0] e_rd1;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Let read data reflect the current rd_addr (one extra edge when registered).
  task automatic settle_reads();
`ifdef IMEM_RDREG_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
  endtask

  task automatic idle_inputs();
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
    bus.ld_clear = 1'b0;
  endtask

  task automatic beat(input logic [5:0] a, input logic [31:0] d, input logic last);
    bus.ld_valid = 1'b1;
    bus.ld_addr  = a;
    bus.ld_data  = d;
    bus.ld_last  = last;
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  initial begin
    tests = 0;
    fails = 0;

    //            v     a      d              last  clr   ra0    ra1    rdy   cnt   hold  err   rd0            rd1
    vecs[0]  = '{1'b1, 6'd0,  32'h2008_0001, 1'b0, 1'b0, 6'd0,  6'd63, 1'b1, 7'd1, 1'b1, 1'b0, 32'h2008_0001, 32'h0};
    vecs[1]  = '{1'b1, 6'd1,  32'h2009_0002, 1'b0, 1'b0, 6'd1,  6'd0,  1'b1, 7'd2, 1'b1, 1'b0, 32'h2009_0002, 32'h2008_0001};
    vecs[2]  = '{1'b1, 6'd2,  32'h0109_5020, 1'b0, 1'b0, 6'd2,  6'd1,  1'b1, 7'd3, 1'b1, 1'b0, 32'h0109_5020, 32'h2009_0002};
    vecs[3]  = '{1'b1, 6'd3,  32'h0800_0003, 1'b1, 1'b0, 6'd2,  6'd10, 1'b1, 7'd4, 1'b0, 1'b0, 32'h0109_5020, 32'h0};
    vecs[4]  = '{1'b1, 6'd0,  32'hFFFF_FFFF, 1'b0, 1'b0, 6'd0,  6'd3,  1'b0, 7'd4, 1'b0, 1'b0, 32'h2008_0001, 32'h0800_0003};
    vecs[5]  = '{1'b0, 6'd0,  32'h0,         1'b0, 1'b0, 6'd10, 6'd10, 1'b0, 7'd4, 1'b0, 1'b0, 32'h0,         32'h0};
    vecs[6]  = '{1'b1, 6'd0,  32'hFFFF_FFFF, 1'b0, 1'b1, 6'd0,  6'd3,  1'b0, 7'd0, 1'b1, 1'b0, 32'h0,         32'h0};
    vecs[7]  = '{1'b1, 6'd1,  32'hAAAA_0000, 1'b0, 1'b0, 6'd1,  6'd0,  1'b1, 7'd1, 1'b1, 1'b0, 32'hAAAA_0000, 32'h0};
    vecs[8]  = '{1'b1, 6'd1,  32'hBBBB_0000, 1'b0, 1'b0, 6'd1,  6'd1,  1'b1, 7'd2, 1'b1, 1'b1, 32'hBBBB_0000, 32'hBBBB_0000};
    vecs[9]  = '{1'b1, 6'd5,  32'h1234_5678, 1'b1, 1'b0, 6'd5,  6'd1,  1'b1, 7'd3, 1'b0, 1'b1, 32'h1234_5678, 32'hBBBB_0000};
    vecs[10] = '{1'b0, 6'd0,  32'h0,         1'b0, 1'b1, 6'd1,  6'd5,  1'b0, 7'd0, 1'b1, 1'b0, 32'h0,         32'h0};

    rst           = 1'b1;
    bus.ld_valid  = 1'b0;
    bus.ld_addr   = '0;
    bus.ld_data   = '0;
    bus.ld_last   = 1'b0;
    bus.ld_clear  = 1'b0;
    bus.rd_addr   = {6'd63, 6'd5};
    bbus.ld_valid = 1'b0;
    bbus.ld_addr  = '0;
    bbus.ld_data  = '0;
    bbus.ld_last  = 1'b0;
    bbus.ld_clear = 1'b0;
    bbus.rd_addr  = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst rd0", bus.rd_data[31:0], 32'h0);
    check("rst rd1", bus.rd_data[63:32], 32'h0);
    check("rst hold", 32'(bus.cpu_hold), 32'h1);
    check("rst count", 32'(bus.ld_count), 32'h0);
    check("rst err", 32'(bus.err_dup), 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle ready", 32'(bus.ld_ready), 32'h1);
    check("idle hold", 32'(bus.cpu_hold), 32'h1);

    // Table: one load-channel cycle per row, then read-back
    for (int i = 0; i < 11; i++) begin
      bus.ld_valid = vecs[i].v;
      bus.ld_addr  = vecs[i].a;
      bus.ld_data  = vecs[i].d;
      bus.ld_last  = vecs[i].last;
      bus.ld_clear = vecs[i].clr;
      #1;
      check($sformatf("v%0d ready", i), 32'(bus.ld_ready), 32'(vecs[i].e_ready));
      @(posedge clk);
      #1;
      idle_inputs();
      bus.rd_addr = {vecs[i].ra1, vecs[i].ra0};
      settle_reads();
      check($sformatf("v%0d count", i), 32'(bus.ld_count), 32'(vecs[i].e_cnt));
      check($sformatf("v%0d hold", i), 32'(bus.cpu_hold), 32'(vecs[i].e_hold));
      check($sformatf("v%0d err", i), 32'(bus.err_dup), 32'(vecs[i].e_err));
      check($sformatf("v%0d rd0", i), bus.rd_data[31:0], vecs[i].e_rd0);
      check($sformatf("v%0d rd1", i), bus.rd_data[63:32], vecs[i].e_rd1);
    end

    // Read-during-write on the same address
    beat(6'd7, 32'h7777_0000, 1'b0);
    bus.ld_valid = 1'b1;
    bus.ld_addr  = 6'd7;
    bus.ld_data  = 32'h8888_0000;
    bus.rd_addr  = {6'd0, 6'd7};
    #1;
`ifndef IMEM_RDREG_EN
    check("rdw pre-edge", bus.rd_data[31:0], 32'h7777_0000);
`endif
    @(posedge clk);
    #1;
    idle_inputs();
`ifdef IMEM_RDREG_EN
    check("rdw old word", bus.rd_data[31:0], 32'h7777_0000);
    @(posedge clk);
    #1;
`endif
    check("rdw new word", bus.rd_data[31:0], 32'h8888_0000);
    check("rdw dup err", 32'(bus.err_dup), 32'h1);

    bus.ld_clear = 1'b1;
    @(posedge clk);
    #1;
    idle_inputs();

    // Asynchronous reset in the middle of a load
    beat(6'd0, 32'h1111_0000, 1'b0);
    beat(6'd1, 32'h2222_0000, 1'b0);
    bus.rd_addr = {6'd1, 6'd0};
    settle_reads();
    check("mid count", 32'(bus.ld_count), 32'h2);
    check("mid rd0", bus.rd_data[31:0], 32'h1111_0000);
    #2;
    rst = 1'b1;
    #1;
    check("arst count", 32'(bus.ld_count), 32'h0);
    check("arst hold", 32'(bus.cpu_hold), 32'h1);
    check("arst ready", 32'(bus.ld_ready), 32'h1);
    check("arst rd0", bus.rd_data[31:0], 32'h0);
    check("arst rd1", bus.rd_data[63:32], 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    beat(6'd2, 32'h3333_0000, 1'b1);
    bus.rd_addr = {6'd0, 6'd2};
    settle_reads();
    check("rearm hold", 32'(bus.cpu_hold), 32'h0);
    check("rearm count", 32'(bus.ld_count), 32'h1);
    check("rearm rd0", bus.rd_data[31:0], 32'h3333_0000);
    check("rearm stale", bus.rd_data[63:32], 32'h0);

    // 4-port, 256-word instance: count saturates, no ld_last
    for (int i = 0; i < 260; i++) begin
      bbus.ld_valid = 1'b1;
      bbus.ld_addr  = 8'(i);
      bbus.ld_data  = 32'hC000_0000 + 32'(i);
      @(posedge clk);
      #1;
      if (i == 255) check("big count full", 32'(bbus.ld_count), 32'd256);
    end
    bbus.ld_valid = 1'b0;
    check("big count sat", 32'(bbus.ld_count), 32'd256);
    check("big hold", 32'(bbus.cpu_hold), 32'h1);
    check("big err", 32'(bbus.err_dup), 32'h1);
    check("big ready", 32'(bbus.ld_ready), 32'h1);
    bbus.rd_addr = {8'd3, 8'd2, 8'd1, 8'd0};
    settle_reads();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("big rd%0d", k), bbus.rd_data[k*32 +: 32], 32'hC000_0100 + 32'(k));
    end
`ifdef IMEM_RDREG_EN
    bbus.rd_addr = {8'd7, 8'd6, 8'd5, 8'd4};
    #1;
    check("lat before edge", bbus.rd_data[31:0], 32'hC000_0100);
    @(posedge clk);
    #1;
    check("lat after edge", bbus.rd_data[31:0], 32'hC000_0004);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
